// File: rtl/sm_multiplier.sv
// -----------------------------------------------------------------------------
// sm_multiplier
//
// Sequential sign-magnitude fixed-point multiplier:
// post_data = pre_data_1 * pre_data_2.
// It feeds the sign-magnitude adder in the sine datapath with the Taylor-series
// product terms. The core is a shift-add engine that forms one partial
// product per clock, so there is no combinational multiplier array.
//
// Number format: bit FXD_N-1 is the sign and bits FXD_N-2:0 hold the
// magnitude. Every operand and the result carry FXD_Q fraction bits.
//
// Parameters
//   FXD_Q        fraction bits (>= 1)
//   FXD_N        total word width (>= FXD_Q+2)
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   pre_avail_1  operand 1 valid
//   pre_get_1    operand 1 consumed this cycle (combinational)
//   pre_data_1   operand 1, sign-magnitude
//   pre_avail_2  operand 2 valid
//   pre_get_2    operand 2 consumed this cycle (combinational)
//   pre_data_2   operand 2, sign-magnitude
//   post_avail   result valid (registered)
//   post_get     downstream takes the result this cycle
//   post_data    product, sign-magnitude (registered)
//   post_ovf     product magnitude saturated; valid while post_avail=1
//
// Configuration macro
//   SM_MULT_ROUND_EN  when defined, the product rounds to nearest with ties
//                     away from zero. When undefined, the product truncates
//                     toward zero.
// -----------------------------------------------------------------------------
module sm_multiplier #(
    parameter int FXD_Q = 4,
    parameter int FXD_N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre_avail_1,
    output logic             pre_get_1,
    input  logic [FXD_N-1:0] pre_data_1,
    input  logic             pre_avail_2,
    output logic             pre_get_2,
    input  logic [FXD_N-1:0] pre_data_2,
    output logic             post_avail,
    input  logic             post_get,
    output logic [FXD_N-1:0] post_data,
    output logic             post_ovf
);

    localparam int MAG_W = FXD_N - 1;           // magnitude width
    localparam int ACC_W = 2 * MAG_W;           // full-precision product width
    localparam int CNT_W = $clog2(MAG_W + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAG_W - 1);
    localparam logic [ACC_W:0]   MAG_MAX_EXT =
        {{(ACC_W + 1 - MAG_W){1'b0}}, {MAG_W{1'b1}}};

    generate
        if (FXD_N < FXD_Q + 2 || FXD_Q < 1) begin : g_bad_param
            $error("sm_multiplier: need FXD_Q >= 1 and FXD_N >= FXD_Q+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   mcand;   // multiplicand, pre-shifted by count
    logic [MAG_W-1:0]   mplier;  // multiplier, bit[count] sits in bit 0
    logic               sign;

    logic               accept;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W:0]     acc_ext;
    logic [ACC_W:0]     mag_full;
    logic               ovf;
    logic [MAG_W-1:0]   mag_sat;
    logic               sign_out;

    // Both operands go together or not at all. In DONE a new pair can be
    // taken on the same edge that hands off the result, so there is no bubble.
    assign accept    = pre_avail_1 && pre_avail_2 &&
                       ((state == IDLE) || ((state == DONE) && post_get));
    assign pre_get_1 = accept;
    assign pre_get_2 = accept;

    // Shifting mcand and mplier each cycle avoids a variable shifter.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // One guard bit lets the rounding increment land without wrap.
`ifdef SM_MULT_ROUND_EN
    localparam logic [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (FXD_Q - 1);
    assign acc_ext = {1'b0, acc_next} + RND_HALF;
`else
    assign acc_ext = {1'b0, acc_next};
`endif

    assign mag_full = acc_ext >> FXD_Q;
    assign ovf      = (mag_full > MAG_MAX_EXT);
    assign mag_sat  = ovf ? {MAG_W{1'b1}} : mag_full[MAG_W-1:0];
    // A zero magnitude always leaves with a positive sign.
    assign sign_out = sign && (mag_sat != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            sign       <= 1'b0;
            post_avail <= 1'b0;
            post_data  <= '0;
            post_ovf   <= 1'b0;
        end else if (accept) begin
            // A sign bit on a zero magnitude needs no special case here.
            // The product is zero and the output normalisation clears it.
            state      <= BUSY;
            count      <= '0;
            acc        <= '0;
            mcand      <= {{MAG_W{1'b0}}, pre_data_1[MAG_W-1:0]};
            mplier     <= pre_data_2[MAG_W-1:0];
            sign       <= pre_data_1[FXD_N-1] ^ pre_data_2[FXD_N-1];
            post_avail <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        state      <= DONE;
                        post_avail <= 1'b1;
                        post_data  <= {sign_out, mag_sat};
                        post_ovf   <= ovf;
                    end
                end
                DONE: begin
                    if (post_get) begin
                        state      <= IDLE;
                        post_avail <= 1'b0;
                    end
                end
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_multiplier.sv
// -----------------------------------------------------------------------------
// tb_sm_multiplier
//
// Self-checking bench for sm_multiplier (FXD_Q=4, FXD_N=8). It runs directed
// cases first, then random operand pairs with random back-pressure and
// back-to-back chaining. A small arithmetic reference model supplies the
// expected result.
// -----------------------------------------------------------------------------
module tb_sm_multiplier;

    localparam int Q = 4;
    localparam int N = 8;
    localparam int LAT = N - 1;
    localparam int MAG_MAX = (1 << (N - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         pre_avail_1, pre_avail_2;
    logic         pre_get_1, pre_get_2;
    logic [N-1:0] pre_data_1, pre_data_2;
    logic         post_avail, post_get, post_ovf;
    logic [N-1:0] post_data;

    int n_tests = 0;
    int n_fail  = 0;

    sm_multiplier #(.FXD_Q(Q), .FXD_N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .pre_avail_1 (pre_avail_1),
        .pre_get_1   (pre_get_1),
        .pre_data_1  (pre_data_1),
        .pre_avail_2 (pre_avail_2),
        .pre_get_2   (pre_get_2),
        .pre_data_2  (pre_data_2),
        .post_avail  (post_avail),
        .post_get    (post_get),
        .post_data   (post_data),
        .post_ovf    (post_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: real-number product scaled by 2^Q, then saturate and
    // normalise the sign. The return value is {ovf, data}.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int  p;
        int  mag;
        bit  o;
        bit  s;
        p = int'(a[N-2:0]) * int'(b[N-2:0]);
`ifdef SM_MULT_ROUND_EN
        p = p + (1 << (Q - 1));
`endif
        mag = p / (1 << Q);
        o   = (mag > MAG_MAX);
        if (o) mag = MAG_MAX;
        s = (a[N-1] != b[N-1]) && (mag != 0);
        return {o, s, mag[N-2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and expect it to be taken on the next edge. Afterwards
    // the avails stay high with junk data, because BUSY must ignore them.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        pre_data_1  = a;
        pre_data_2  = b;
        pre_avail_1 = 1'b1;
        pre_avail_2 = 1'b1;
        #1;
        chk("accept_get1", 32'(pre_get_1), 32'd1);
        chk("accept_get2", 32'(pre_get_2), 32'd1);
        tick();
        pre_data_1 = N'($urandom);
        pre_data_2 = N'($urandom);
    endtask

    // Wait for the result of (a,b) and check its latency and value. Then
    // stall for 'hold' cycles. Finally hand off the result, either alone or
    // together with the next pair (na,nb) when 'chain' is set.
    task automatic collect(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                           input bit chain, input logic [N-1:0] na, input logic [N-1:0] nb);
        int         lat;
        bit         busy_get;
        logic [N:0] e;
        lat      = 0;
        busy_get = 1'b0;
        post_get = 1'b0;
        while (!post_avail && lat < 3 * LAT) begin
            if (pre_get_1 || pre_get_2) busy_get = 1'b1;
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        chk("busy_no_get", 32'(busy_get), 32'd0);
        e = model(a, b);
        chk("post_data", 32'(post_data), 32'(e[N-1:0]));
        chk("post_ovf", 32'(post_ovf), 32'(e[N]));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_avail", 32'(post_avail), 32'd1);
            chk("hold_data", 32'(post_data), 32'(e[N-1:0]));
            chk("hold_ovf", 32'(post_ovf), 32'(e[N]));
            chk("hold_no_get", 32'(pre_get_1 | pre_get_2), 32'd0);
        end
        if (chain) begin
            pre_data_1  = na;
            pre_data_2  = nb;
            pre_avail_1 = 1'b1;
            pre_avail_2 = 1'b1;
            post_get    = 1'b1;
            #1;
            chk("chain_get", 32'(pre_get_1 & pre_get_2), 32'd1);
            tick();
            post_get   = 1'b0;
            pre_data_1 = N'($urandom);
            pre_data_2 = N'($urandom);
            chk("chain_avail_drop", 32'(post_avail), 32'd0);
        end else begin
            pre_avail_1 = 1'b0;
            pre_avail_2 = 1'b0;
            post_get    = 1'b1;
            #1;
            chk("idle_no_get", 32'(pre_get_1 | pre_get_2), 32'd0);
            tick();
            post_get = 1'b0;
            chk("avail_drop", 32'(post_avail), 32'd0);
        end
    endtask

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] a, b, na, nb;
        bit           ch;
        int           seen;

        rst         = 1'b1;
        pre_avail_1 = 1'b0;
        pre_avail_2 = 1'b0;
        pre_data_1  = '0;
        pre_data_2  = '0;
        post_get    = 1'b0;
        tick();
        tick();
        chk("rst_avail", 32'(post_avail), 32'd0);
        chk("rst_data", 32'(post_data), 32'd0);
        chk("rst_ovf", 32'(post_ovf), 32'd0);
        rst = 1'b0;
        pre_avail_1 = 1'b1;
        #1;
        chk("one_operand_no_get", 32'(pre_get_1 | pre_get_2), 32'd0);
        pre_avail_1 = 1'b0;
        tick();

        // Directed cases from the plan. Basic case then back-pressure with chain.
        issue(8'h18, 8'hA0);
        collect(8'h18, 8'hA0, 5, 1'b1, 8'h78, 8'h40);
        collect(8'h78, 8'h40, 0, 1'b0, 8'h00, 8'h00);
        issue(8'hF8, 8'h40); collect(8'hF8, 8'h40, 0, 1'b0, 8'h00, 8'h00);
        issue(8'h81, 8'h01); collect(8'h81, 8'h01, 1, 1'b0, 8'h00, 8'h00);
        issue(8'h03, 8'h03); collect(8'h03, 8'h03, 0, 1'b0, 8'h00, 8'h00);
        issue(8'h83, 8'h03); collect(8'h83, 8'h03, 0, 1'b0, 8'h00, 8'h00);
        issue(8'h80, 8'hFF); collect(8'h80, 8'hFF, 0, 1'b0, 8'h00, 8'h00);

        // Reset three cycles into BUSY: the product is discarded.
        issue(8'h18, 8'h18);
        tick();
        tick();
        pre_avail_1 = 1'b0;
        pre_avail_2 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_avail", 32'(post_avail), 32'd0);
        seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            if (post_avail) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        issue(8'h24, 8'h9C); collect(8'h24, 8'h9C, 0, 1'b0, 8'h00, 8'h00);

        // Random traffic with mixed back-pressure and chaining.
        a = rand_op();
        b = rand_op();
        issue(a, b);
        for (int i = 0; i < 60; i++) begin
            na = rand_op();
            nb = rand_op();
            ch = 1'($urandom_range(0, 1));
            collect(a, b, $urandom_range(0, 3), ch, na, nb);
            if (!ch) begin
                if ($urandom_range(0, 1) == 1) tick();
                issue(na, nb);
            end
            a = na;
            b = nb;
        end
        collect(a, b, 0, 1'b0, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
